datmem_port_arbiter: RTL and testbench
======================================

Name: datmem_port_arbiter

Overview:
Shares the single byte-wide, 32-location data memory between two word-oriented requesters: port 0 is the processor and port 1 is the loader/debug port.
- Each granted request becomes four sequential byte accesses in big-endian order. Byte addr+0 carries word bits [31:24].
- Arbitration between the two ports is round-robin.
- The block sits between the requesters and the datmem array. It replaces direct 4-byte parallel access with a sequenced, single-ported access.

Parameters:
ADDR_W, 5, byte address width; memory depth is 2**ADDR_W.
DATA_W, 32, requester word width.
BYTE_W, 8, memory location width; BEATS = DATA_W/BYTE_W = 4.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
req0  in  1  port 0 (processor) request; level, held until done0.
we0  in  1  port 0 write (1) / read (0).
addr0  in  ADDR_W  port 0 byte start address.
wdata0  in  DATA_W  port 0 write word.
done0  out  1  port 0 one-cycle completion pulse.
rdata0  out  DATA_W  port 0 read word.
req1, we1, addr1, wdata1, done1, rdata1: same definitions as port 0, for port 1.
busy  out  1  transfer in progress.
mem_addr  out  ADDR_W  byte address to datmem.
mem_we  out  1  byte write strobe; memory writes on posedge when high.
mem_wdata  out  BYTE_W  byte write data.
mem_rdata  in  BYTE_W  combinational read data at mem_addr.

Behaviour:
- States: IDLE, XFER, DONE. Beat counter beat[1:0]. Round-robin pointer last (0/1).
- Reset values: state=IDLE, beat=0, last=1 (so port 0 wins the first tie), done0/done1=0, rdata0/rdata1=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0.
- IDLE:
  - If any req is high, latch owner, we, addr and wdata, and go to XFER with beat=0.
  - Owner selection: if both req are high, owner = ~last; otherwise the single requester wins.
- XFER, beat k = 0..3:
  - mem_addr = (latched addr + k) mod 2**ADDR_W. Wrap-around is natural, e.g. addr 30 gives beats 30, 31, 0, 1.
  - Write: mem_we=1, mem_wdata = wdata[DATA_W-1-8k -: 8].
  - Read: mem_we=0, and mem_rdata is captured into shift register bits [DATA_W-1-8k -: 8] at the posedge.
  - At beat 3 go to DONE.
  - busy=1 throughout XFER.
- DONE:
  - done<owner>=1 for exactly one cycle.
  - For a read, rdata<owner> is loaded from the shift register at the XFER→DONE edge and held until that port's next read completes. Writes never change rdata.
  - last := owner. Next state is IDLE.
  - busy=0 in DONE.
- Latency: request seen at edge N → memory beats on cycles N+1..N+4 → done at N+5. Minimum spacing between grants is 6 cycles.
- A request dropped mid-transfer does not abort it; the transfer completes and done still pulses.
- Inputs changing mid-transfer are ignored; only the latched copies are used.
- The owner's req still high in the DONE cycle is treated as a new request at the following IDLE evaluation, still subject to round-robin.
- Reset asserted mid-XFER returns to IDLE on the next edge with no done pulse. Bytes already written stay written; a partial word in memory is acceptable.
- mem_we is never asserted outside XFER.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, XFER=2'd1, DONE=2'd2;
  - BEATS constant;
  - port index constants PORT_CPU=0, PORT_DBG=1.
- One natural sub-module: rr_arbiter2, a 2-requester round-robin pick with last-grant input that outputs the owner index. Everything else is inline.

Test Plan:
- Port 0 write, addr=4, wdata=0xDEADBEEF → mem writes DE@4, AD@5, BE@6, EF@7 on consecutive cycles; done0 pulses 5 cycles after req; done1 stays 0.
- Port 1 read, addr=4, after the write above → rdata1=0xDEADBEEF when done1 pulses; rdata0 unchanged.
- Wrap: port 0 write addr=30, wdata=0x11223344 → bytes 11@30, 22@31, 33@0, 44@1.
- Both req high from reset → port 0 served first and port 1 second. Then, with both still high, grants alternate 0,1,0,1 across four transfers.
- req0 dropped after 2 beats → remaining beats still issued; done0 pulses once; no new transfer starts.
- Reset asserted at beat 2 of a write of 0xAABBCCDD at addr 8 → next cycle IDLE, busy=0, no done pulse; mem[8]=AA, mem[9]=BB, mem[10..11] hold their old values.

Source files
------------

// File: rtl/datmem_port_arbiter_pkg.sv
// Shared definitions for the datmem port arbiter: FSM encoding, beat count
// and requester port indices.
package datmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BEATS = 4;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/datmem_port_arbiter_rr.sv
// Two-requester round-robin pick: on a tie the port that did not win last
// time is chosen; a lone requester always wins.
module rr_arbiter2
  import datmem_port_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic owner
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      owner = ~last;
    end else if (req1) begin
      owner = PORT_DBG;
    end else begin
      owner = PORT_CPU;
    end
  end

endmodule

// File: rtl/datmem_port_arbiter.sv
// Sequences word requests from the processor and loader/debug ports into four
// big-endian byte accesses on the single-ported byte-wide data memory.
module datmem_port_arbiter
  import datmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [BYTE_W-1:0] mem_wdata,
  input  logic [BYTE_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wsh_q, wsh_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                busy_q, busy_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [BYTE_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                grant_valid;
  logic                grant_owner;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  rr_arbiter2 u_rr (
    .req0  (req0),
    .req1  (req1),
    .last  (last_q),
    .valid (grant_valid),
    .owner (grant_owner)
  );

  assign sel_we    = (grant_owner == PORT_DBG) ? we1    : we0;
  assign sel_addr  = (grant_owner == PORT_DBG) ? addr1  : addr0;
  assign sel_wdata = (grant_owner == PORT_DBG) ? wdata1 : wdata0;

  // Memory-side outputs are registered one beat ahead, so each XFER cycle
  // already presents the address and byte for its own beat.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    last_d      = last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    wsh_d       = wsh_q;
    shift_d     = shift_q;
    busy_d      = busy_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d     = XFER;
          beat_d      = '0;
          owner_d     = grant_owner;
          we_d        = sel_we;
          busy_d      = 1'b1;
          mem_addr_d  = sel_addr;
          mem_we_d    = sel_we;
          mem_wdata_d = sel_wdata[DATA_W-1 -: BYTE_W];
          wsh_d       = sel_wdata << BYTE_W;
        end
      end
      XFER: begin
        shift_d = (shift_q << BYTE_W) | DATA_W'(mem_rdata);
        if (beat_q == LAST_BEAT) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          mem_we_d = 1'b0;
          last_d   = owner_q;
          if (owner_q == PORT_DBG) begin
            done1_d = 1'b1;
            if (!we_q) rdata1_d = shift_d;
          end else begin
            done0_d = 1'b1;
            if (!we_q) rdata0_d = shift_d;
          end
        end else begin
          beat_d      = beat_q + 2'd1;
          mem_addr_d  = mem_addr_q + ADDR_W'(1);
          mem_wdata_d = wsh_q[DATA_W-1 -: BYTE_W];
          wsh_d       = wsh_q << BYTE_W;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      last_q      <= 1'b1;
      owner_q     <= PORT_CPU;
      we_q        <= 1'b0;
      wsh_q       <= '0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      wsh_q       <= wsh_d;
      shift_q     <= shift_d;
      busy_q      <= busy_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_datmem_port_arbiter.sv
// Bench for datmem_port_arbiter: a byte memory model behind the DUT and a
// word-level reference model of memory contents and per-port read results.
module tb_datmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        done0, done1, busy, mem_we;
  logic [31:0] rdata0, rdata1;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  datmem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .done0     (done0),
    .rdata0    (rdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .done1     (done1),
    .rdata1    (rdata1),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Byte memory the DUT drives, plus a monitor logging writes and done pulses.
  logic [7:0] mem [32];
  logic       mem_clear;
  int         cyc = 0;
  int         done0_cnt = 0;
  int         done1_cnt = 0;
  int         we_viol = 0;
  int         wlog_addr [$];
  int         wlog_data [$];
  int         wlog_cyc  [$];

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done0) done0_cnt <= done0_cnt + 1;
    if (done1) done1_cnt <= done1_cnt + 1;
    if (mem_we) begin
      wlog_addr.push_back(int'(mem_addr));
      wlog_data.push_back(int'(mem_wdata));
      wlog_cyc.push_back(cyc);
      if (!busy) we_viol <= we_viol + 1;
    end
  end

  int          total = 0;
  int          bad = 0;
  logic [7:0]  ref_mem [32];
  logic [31:0] exp_rdata [2];

  function automatic logic [31:0] ref_read(input int a);
    logic [31:0] r = 0;
    for (int k = 0; k < 4; k++) r = r * 256 + 32'(ref_mem[(a + k) % 32]);
    return r;
  endfunction

  function automatic int byte_of(input logic [31:0] w, input int k);
    return int'((w >> (8 * (3 - k))) % 256);
  endfunction

  task automatic ref_write(input int a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) ref_mem[(a + k) % 32] = 8'(byte_of(w, k));
  endtask

  // Drives one request from an IDLE negedge, waits (bounded) for its done
  // pulse and returns latency in cycles and the port's rdata at that point.
  task automatic run_xfer(input int port, input logic we, input logic [4:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd);
    if (port == 1) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
    end
    lat = -1;
    rd  = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ((port == 1) ? done1 : done0) begin
        lat = k;
        rd  = (port == 1) ? rdata1 : rdata0;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    we0 = $urandom_range(0, 1); addr0 = 5'($urandom); wdata0 = $urandom;
    we1 = $urandom_range(0, 1); addr1 = 5'($urandom); wdata1 = $urandom;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_clear = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    total++; if ({done0, done1} !== 2'b00) begin bad++; $display("[TB] FAIL reset_done got=%b exp=00", {done0, done1}); end
    total++; if (rdata0 !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata0 got=%h exp=0", rdata0); end
    total++; if (rdata1 !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata1 got=%h exp=0", rdata1); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== 5'h0) begin bad++; $display("[TB] FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== 8'h0) begin bad++; $display("[TB] FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    reset = 1'b0; mem_clear = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
    exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_write_cpu();
    int lat, w0, d0, d1;
    logic [31:0] rd;
    w0 = wlog_addr.size(); d0 = done0_cnt; d1 = done1_cnt;
    run_xfer(0, 1'b1, 5'd4, 32'hDEADBEEF, lat, rd);
    ref_write(4, 32'hDEADBEEF);
    total++; if (lat !== 5) begin bad++; $display("[TB] FAIL wr_latency got=%0d exp=5", lat); end
    total++; if (wlog_addr.size() - w0 !== 4) begin bad++; $display("[TB] FAIL wr_beats got=%0d exp=4", wlog_addr.size() - w0); end
    else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (wlog_addr[w0+k] !== 4 + k || wlog_data[w0+k] !== byte_of(32'hDEADBEEF, k) ||
            wlog_cyc[w0+k] !== wlog_cyc[w0] + k) begin
          bad++;
          $display("[TB] FAIL wr_beat%0d got=%h@%0d exp=%h@%0d", k, wlog_data[w0+k], wlog_addr[w0+k],
                   byte_of(32'hDEADBEEF, k), 4 + k);
        end
      end
    end
    total++; if (done0_cnt - d0 !== 1) begin bad++; $display("[TB] FAIL wr_done0_count got=%0d exp=1", done0_cnt - d0); end
    total++; if (done1_cnt - d1 !== 0) begin bad++; $display("[TB] FAIL wr_done1_quiet got=%0d exp=0", done1_cnt - d1); end
  endtask

  task automatic test_read_dbg();
    int lat, w0;
    logic [31:0] rd;
    w0 = wlog_addr.size();
    run_xfer(1, 1'b0, 5'd4, $urandom, lat, rd);
    total++; if (lat !== 5) begin bad++; $display("[TB] FAIL rd_latency got=%0d exp=5", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL rd_rdata1 got=%h exp=deadbeef", rd); end
    exp_rdata[1] = 32'hDEADBEEF;
    total++; if (rdata0 !== exp_rdata[0]) begin bad++; $display("[TB] FAIL rd_rdata0_kept got=%h exp=%h", rdata0, exp_rdata[0]); end
    total++; if (wlog_addr.size() !== w0) begin bad++; $display("[TB] FAIL rd_no_write got=%0d exp=0", wlog_addr.size() - w0); end
  endtask

  task automatic test_wrap();
    int lat, w0;
    int exp_a [4] = '{30, 31, 0, 1};
    logic [31:0] rd;
    w0 = wlog_addr.size();
    run_xfer(0, 1'b1, 5'd30, 32'h11223344, lat, rd);
    ref_write(30, 32'h11223344);
    total++; if (wlog_addr.size() - w0 !== 4) begin bad++; $display("[TB] FAIL wrap_beats got=%0d exp=4", wlog_addr.size() - w0); end
    else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (wlog_addr[w0+k] !== exp_a[k] || wlog_data[w0+k] !== byte_of(32'h11223344, k)) begin
          bad++;
          $display("[TB] FAIL wrap_beat%0d got=%h@%0d exp=%h@%0d", k, wlog_data[w0+k], wlog_addr[w0+k],
                   byte_of(32'h11223344, k), exp_a[k]);
        end
      end
    end
  endtask

  task automatic test_drop();
    int w0, d0, first_k;
    logic [31:0] wd;
    wd = $urandom;
    w0 = wlog_addr.size(); d0 = done0_cnt; first_k = -1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd16; wdata0 = wd;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 3) begin
        req0 = 1'b0; we0 = 1'b0; addr0 = 5'd3; wdata0 = $urandom;
      end
      if (done0 && first_k < 0) first_k = k;
    end
    ref_write(16, wd);
    total++; if (first_k !== 5) begin bad++; $display("[TB] FAIL drop_done_time got=%0d exp=5", first_k); end
    total++; if (done0_cnt - d0 !== 1) begin bad++; $display("[TB] FAIL drop_done_count got=%0d exp=1", done0_cnt - d0); end
    total++; if (wlog_addr.size() - w0 !== 4) begin bad++; $display("[TB] FAIL drop_beats got=%0d exp=4", wlog_addr.size() - w0); end
    else begin
      total++;
      if (wlog_addr[w0+3] !== 19 || wlog_data[w0+3] !== byte_of(wd, 3)) begin
        bad++; $display("[TB] FAIL drop_last_beat got=%h@%0d exp=%h@19", wlog_data[w0+3], wlog_addr[w0+3], byte_of(wd, 3));
      end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL drop_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int d0;
    logic [7:0] old10, old11;
    old10 = ref_mem[10]; old11 = ref_mem[11];
    d0 = done0_cnt;
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd8; wdata0 = 32'hAABBCCDD;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_mem_we got=%b exp=0", mem_we); end
    req0 = 1'b0; reset = 1'b0;
    repeat (6) @(negedge clk);
    ref_mem[8] = 8'hAA; ref_mem[9] = 8'hBB;
    exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
    total++; if (done0_cnt - d0 !== 0) begin bad++; $display("[TB] FAIL rstmid_no_done got=%0d exp=0", done0_cnt - d0); end
    total++;
    if (mem[8] !== 8'hAA || mem[9] !== 8'hBB || mem[10] !== old10 || mem[11] !== old11) begin
      bad++;
      $display("[TB] FAIL rstmid_mem got=%h%h%h%h exp=aabb%h%h", mem[8], mem[9], mem[10], mem[11], old10, old11);
    end
    total++; if (rdata1 !== 32'h0) begin bad++; $display("[TB] FAIL rstmid_rdata1 got=%h exp=0", rdata1); end
  endtask

  task automatic test_round_robin();
    int n, prev_i;
    int port;
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd4;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd30;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
    n = 0; prev_i = -1;
    for (int i = 1; i <= 80 && n < 6; i++) begin
      @(negedge clk);
      if (done0 || done1) begin
        port = done1 ? 1 : 0;
        total++; if (done0 && done1) begin bad++; $display("[TB] FAIL rr_both_done got=11 exp=one-hot"); end
        total++; if (port !== n % 2) begin bad++; $display("[TB] FAIL rr_order%0d got=%0d exp=%0d", n, port, n % 2); end
        total++;
        if (i !== ((prev_i < 0) ? 5 : prev_i + 6)) begin
          bad++; $display("[TB] FAIL rr_timing%0d got=%0d exp=%0d", n, i, (prev_i < 0) ? 5 : prev_i + 6);
        end
        exp_rdata[port] = ref_read((port == 1) ? 30 : 4);
        total++;
        if (((port == 1) ? rdata1 : rdata0) !== exp_rdata[port]) begin
          bad++; $display("[TB] FAIL rr_rdata%0d got=%h exp=%h", port, (port == 1) ? rdata1 : rdata0, exp_rdata[port]);
        end
        prev_i = i;
        n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    total++; if (n !== 6) begin bad++; $display("[TB] FAIL rr_grant_count got=%0d exp=6", n); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int lat, w0, port, a;
    logic we;
    logic [31:0] wd, rd, exp;
    for (int it = 0; it < 16; it++) begin
      port = $urandom_range(0, 1);
      we   = $urandom_range(0, 1);
      a    = $urandom_range(0, 31);
      wd   = $urandom;
      exp  = ref_read(a);
      w0   = wlog_addr.size();
      run_xfer(port, we, 5'(a), wd, lat, rd);
      total++; if (lat !== 5) begin bad++; $display("[TB] FAIL rnd%0d_latency got=%0d exp=5", it, lat); end
      if (we) begin
        ref_write(a, wd);
        total++; if (wlog_addr.size() - w0 !== 4) begin bad++; $display("[TB] FAIL rnd%0d_beats got=%0d exp=4", it, wlog_addr.size() - w0); end
        total++; if (rd !== exp_rdata[port]) begin bad++; $display("[TB] FAIL rnd%0d_wr_rdata got=%h exp=%h", it, rd, exp_rdata[port]); end
      end else begin
        exp_rdata[port] = exp;
        total++; if (rd !== exp) begin bad++; $display("[TB] FAIL rnd%0d_rdata got=%h exp=%h", it, rd, exp); end
      end
      total++;
      if (((port == 1) ? rdata0 : rdata1) !== exp_rdata[1-port]) begin
        bad++; $display("[TB] FAIL rnd%0d_other_rdata got=%h exp=%h", it, (port == 1) ? rdata0 : rdata1, exp_rdata[1-port]);
      end
    end
  endtask

  task automatic test_final();
    int diffs = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) diffs++;
    total++; if (diffs !== 0) begin bad++; $display("[TB] FAIL mem_image got=%0d differing bytes exp=0", diffs); end
    total++; if (we_viol !== 0) begin bad++; $display("[TB] FAIL mem_we_outside_xfer got=%0d exp=0", we_viol); end
  endtask

  initial begin
    reset = 1'b1; mem_clear = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    @(negedge clk);
    test_reset();
    test_write_cpu();
    test_read_dbg();
    test_wrap();
    test_drop();
    test_reset_mid();
    test_round_robin();
    test_random();
    test_final();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
